ram_arbiter: RTL and testbench
==============================

RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 4, RAM address width.
REQ-002 Parameter DATA_WIDTH, default 32, RAM data width.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rstn  input  1  asynchronous, active-low reset.
REQ-005 req  input  2  per-requester access request; bit i = requester i.
REQ-006 we  input  2  per-requester op: 1 = write, 0 = read.
REQ-007 addr  input  2*ADDR_WIDTH  requester i address at bits [i*ADDR_WIDTH +: ADDR_WIDTH].
REQ-008 wdata  input  2*DATA_WIDTH  requester i write data at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-009 gnt  output  2  one-cycle pulse; request accepted and issued to RAM.
REQ-010 rdata  output  DATA_WIDTH  read data, valid only while rvalid is nonzero.
REQ-011 rvalid  output  2  one-cycle pulse; rdata belongs to requester i.
REQ-012 ram_en  output  1  RAM write enable; 0 = read.
REQ-013 ram_addr  output  ADDR_WIDTH  RAM address.
REQ-014 ram_wdata  output  DATA_WIDTH  RAM write data.
REQ-015 ram_rdata  input  DATA_WIDTH  RAM registered read data.
REQ-016 ram_valid  input  1  RAM read-valid flag.
REQ-017 err  output  1  sticky protocol-error flag.

Function
REQ-018 FSM states: IDLE, ISSUE, RESP; exactly one op in flight.
REQ-019 IDLE with any req bit set: choose winner, latch winner, we, addr, wdata, and go to ISSUE next edge; else stay IDLE.
REQ-020 Winner: the only requester if one; if both, the requester not granted last (round-robin); last-grant register resets to 1, so requester 0 wins the first tie.
REQ-021 ISSUE: gnt[winner]=1; ram_addr=latched addr; ram_en=latched we; ram_wdata=latched wdata; last-grant updated at end of cycle.
REQ-022 ISSUE with write: next state IDLE; write completes at the ISSUE edge; no rvalid.
REQ-023 ISSUE with read: next state RESP.
REQ-024 RESP: ram_en=0, ram_addr held; rdata<=ram_rdata and rvalid[winner]<=1 at end of RESP, so rvalid pulses in the following cycle (IDLE); next state IDLE.
REQ-025 Read latency: req sampled in cycle N -> gnt in N+1 -> rvalid in N+3; write: gnt in N+1, data in RAM after the N+1 edge.
REQ-026 RESP with ram_valid=0: err<=1; rvalid still pulses with captured data.
REQ-027 Outside ISSUE, ram_en SHALL be 0; no spurious writes in any state.
REQ-028 Requesters hold req, we, addr and wdata stable until gnt; req still high in the IDLE after completion is a new request.
REQ-029 Back-to-back: write takes 2 cycles per op, read 3; requests arriving while busy wait, with no loss.
REQ-030 All outputs decode from registered state only; no combinational path from req/we/addr/wdata to any output.

Reset
REQ-031 rstn low: state=IDLE, gnt=0, rvalid=0, rdata=0, ram_en=0, ram_addr=0, ram_wdata=0, err=0, last-grant=1, immediately and asynchronously.
REQ-032 Reset during ISSUE or RESP aborts the op with no gnt or rvalid afterwards; a requester re-requests after reset.

Structure
REQ-033 Package ram_arb_pkg holds the state enum (IDLE, ISSUE, RESP) and the requester count constant (2).
REQ-034 Sub-module rr_arbiter2 holds the round-robin choice and last-grant register; ram_arbiter instantiates it once.

Verification
REQ-035 req=01, we=01, addr0=3, wdata0=0xDEADBEEF -> gnt=01 one cycle with ram_en=1, ram_addr=3; a later read of 3 by requester 1 returns 0xDEADBEEF on rvalid=10.
REQ-036 req=11, both reads, addr 5 and 6 held -> gnt order 01 then 10; rvalid 01 then 10 with mem[5] then mem[6].
REQ-037 req=11 held 6 ops -> gnt alternates 01,10,01,10,01,10; ram_en never 1 outside ISSUE.
REQ-038 Read from requester 0, req sampled in cycle N -> gnt in N+1, rvalid=01 in N+3, rdata=mem[addr].
REQ-039 rstn pulled low during RESP -> all outputs 0 immediately; no rvalid after release; next request served normally.
REQ-040 RAM model forces ram_valid=0 during RESP -> err=1, held until rstn.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the two-requester RAM arbiter.
package ram_arb_pkg;

  localparam int NUM_REQ = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  function automatic logic [NUM_REQ-1:0] onehot(input logic idx);
    logic [NUM_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/ram_arbiter_if.sv
// Requester-side and RAM-side bus of the arbiter; slave = arbiter, master = environment.
interface ram_arbiter_if
  import ram_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
) ();

  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ-1:0]            we;
  logic [NUM_REQ*ADDR_WIDTH-1:0] addr;
  logic [NUM_REQ*DATA_WIDTH-1:0] wdata;
  logic [NUM_REQ-1:0]            gnt;
  logic [DATA_WIDTH-1:0]         rdata;
  logic [NUM_REQ-1:0]            rvalid;
  logic                          ram_en;
  logic [ADDR_WIDTH-1:0]         ram_addr;
  logic [DATA_WIDTH-1:0]         ram_wdata;
  logic [DATA_WIDTH-1:0]         ram_rdata;
  logic                          ram_valid;
  logic                          err;

  modport slave (
    input  req, we, addr, wdata, ram_rdata, ram_valid,
    output gnt, rdata, rvalid, ram_en, ram_addr, ram_wdata, err
  );

  modport master (
    output req, we, addr, wdata, ram_rdata, ram_valid,
    input  gnt, rdata, rvalid, ram_en, ram_addr, ram_wdata, err
  );

endinterface

// File: rtl/ram_arbiter_rr.sv
// Two-way round-robin choice; last_reg remembers who was granted most recently.
module rr_arbiter2
  import ram_arb_pkg::*;
(
  input  logic               clk,
  input  logic               rstn,
  input  logic [NUM_REQ-1:0] req,
  input  logic               update,
  input  logic               grant_idx,
  output logic               winner
);

  logic last_reg;

  // Reset to requester 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      last_reg <= 1'b1;
    end else if (update) begin
      last_reg <= grant_idx;
    end
  end

  always_comb begin
    winner = 1'b0;
    if (req == 2'b10) begin
      winner = 1'b1;
    end else if (req == 2'b11) begin
      winner = ~last_reg;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Serialises two requesters onto one single-port RAM, one operation in flight.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic          clk,
  input  logic          rstn,
  ram_arbiter_if.slave  bus
);

  state_t                state_reg, state_next;
  logic                  win_reg;
  logic                  we_reg;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [DATA_WIDTH-1:0] wdata_reg;
  logic [DATA_WIDTH-1:0] rdata_reg;
  logic [NUM_REQ-1:0]    rvalid_reg;
  logic                  err_reg;

  logic                  winner;
  logic                  arb_update;
  logic [NUM_REQ-1:0]    gnt_dec;
  logic                  ram_en_dec;

  logic [ADDR_WIDTH-1:0] addr_arr  [NUM_REQ];
  logic [DATA_WIDTH-1:0] wdata_arr [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign addr_arr[gi]  = bus.addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdata_arr[gi] = bus.wdata[gi*DATA_WIDTH +: DATA_WIDTH];
  end

  rr_arbiter2 u_rr (
    .clk       (clk),
    .rstn      (rstn),
    .req       (bus.req),
    .update    (arb_update),
    .grant_idx (win_reg),
    .winner    (winner)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Outputs decode from state and latched fields only, never from live requests.
  always_comb begin
    state_next = state_reg;
    gnt_dec    = '0;
    ram_en_dec = 1'b0;
    arb_update = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (|bus.req) begin
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        gnt_dec    = onehot(win_reg);
        ram_en_dec = we_reg;
        arb_update = 1'b1;
        state_next = we_reg ? IDLE : RESP;
      end
      RESP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      win_reg    <= 1'b0;
      we_reg     <= 1'b0;
      addr_reg   <= '0;
      wdata_reg  <= '0;
      rdata_reg  <= '0;
      rvalid_reg <= '0;
      err_reg    <= 1'b0;
    end else begin
      rvalid_reg <= '0;
      if (state_reg == IDLE && (|bus.req)) begin
        win_reg   <= winner;
        we_reg    <= bus.we[winner];
        addr_reg  <= addr_arr[winner];
        wdata_reg <= wdata_arr[winner];
      end
      // A missing ram_valid is flagged but the captured word is still delivered.
      if (state_reg == RESP) begin
        rdata_reg  <= bus.ram_rdata;
        rvalid_reg <= onehot(win_reg);
        if (!bus.ram_valid) begin
          err_reg <= 1'b1;
        end
      end
    end
  end

  assign bus.gnt       = gnt_dec;
  assign bus.ram_en    = ram_en_dec;
  assign bus.ram_addr  = addr_reg;
  assign bus.ram_wdata = wdata_reg;
  assign bus.rdata     = rdata_reg;
  assign bus.rvalid    = rvalid_reg;
  assign bus.err       = err_reg;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a registered-read RAM model.
module tb_ram_arbiter;

  localparam int AW = 4;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic load = 1'b1;
  logic force_bad = 1'b0;
  int   checks = 0;
  int   errors = 0;

  logic [DW-1:0] mem [16];

  always #5 clk = ~clk;

  ram_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  // RAM model: write on ram_en, registered read every cycle.
  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < 16; i++) mem[i] <= DW'(32'h1000_0000 + i);
    end else if (bus.ram_en) begin
      mem[bus.ram_addr] <= bus.ram_wdata;
    end
    bus.ram_rdata <= mem[bus.ram_addr];
    bus.ram_valid <= ~force_bad;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(negedge clk);
  endtask

  task automatic set_req(input logic [1:0] r, input logic [1:0] w,
                         input logic [3:0] a0, input logic [3:0] a1,
                         input logic [31:0] d0, input logic [31:0] d1);
    bus.req   = r;
    bus.we    = w;
    bus.addr  = {a1, a0};
    bus.wdata = {d1, d0};
  endtask

  initial begin
    logic [1:0] exp_g;
    set_req(2'b00, 2'b00, 4'd0, 4'd0, 32'h0, 32'h0);
    repeat (2) step;
    load = 1'b0;
    check("rst_gnt", bus.gnt, 0);
    check("rst_rvalid", bus.rvalid, 0);
    check("rst_ram_en", bus.ram_en, 0);
    check("rst_ram_addr", bus.ram_addr, 0);
    check("rst_rdata", bus.rdata, 0);
    check("rst_err", bus.err, 0);
    rstn = 1'b1;

    // Write 0xDEADBEEF to address 3 from requester 0
    set_req(2'b01, 2'b01, 4'd3, 4'd0, 32'hDEAD_BEEF, 32'h0);
    step;
    check("wr_gnt", bus.gnt, 2'b01);
    check("wr_ram_en", bus.ram_en, 1);
    check("wr_ram_addr", bus.ram_addr, 3);
    check("wr_ram_wdata", bus.ram_wdata, 32'hDEAD_BEEF);
    set_req(2'b00, 2'b00, 4'd0, 4'd0, 32'h0, 32'h0);
    step;
    check("wr_idle_gnt", bus.gnt, 0);
    check("wr_idle_en", bus.ram_en, 0);

    // Requester 1 reads it back
    set_req(2'b10, 2'b00, 4'd0, 4'd3, 32'h0, 32'h0);
    step;
    check("rd_gnt", bus.gnt, 2'b10);
    check("rd_ram_en", bus.ram_en, 0);
    check("rd_ram_addr", bus.ram_addr, 3);
    set_req(2'b00, 2'b00, 4'd0, 4'd0, 32'h0, 32'h0);
    step;
    check("rd_resp_rvalid", bus.rvalid, 0);
    check("rd_resp_en", bus.ram_en, 0);
    check("rd_resp_addr", bus.ram_addr, 3);
    step;
    check("rd_rvalid", bus.rvalid, 2'b10);
    check("rd_rdata", bus.rdata, 32'hDEAD_BEEF);

    // Tie on reads of 5 and 6
    set_req(2'b11, 2'b00, 4'd5, 4'd6, 32'h0, 32'h0);
    step;
    check("tie_gnt0", bus.gnt, 2'b01);
    set_req(2'b10, 2'b00, 4'd5, 4'd6, 32'h0, 32'h0);
    step;
    step;
    check("tie_rvalid0", bus.rvalid, 2'b01);
    check("tie_rdata0", bus.rdata, 32'h1000_0005);
    step;
    check("tie_gnt1", bus.gnt, 2'b10);
    set_req(2'b00, 2'b00, 4'd0, 4'd0, 32'h0, 32'h0);
    step;
    step;
    check("tie_rvalid1", bus.rvalid, 2'b10);
    check("tie_rdata1", bus.rdata, 32'h1000_0006);

    // Both held for six writes: grants alternate, ram_en only in ISSUE
    set_req(2'b11, 2'b11, 4'd8, 4'd9, 32'hA5A5_0008, 32'h5A5A_0009);
    for (int k = 0; k < 12; k++) begin
      step;
      exp_g = (k % 2 == 1) ? 2'b00 : (((k / 2) % 2 == 0) ? 2'b01 : 2'b10);
      check("alt_gnt", bus.gnt, exp_g);
      check("alt_ram_en", bus.ram_en, (k % 2 == 0) ? 1 : 0);
      if (k == 11) set_req(2'b00, 2'b00, 4'd0, 4'd0, 32'h0, 32'h0);
    end

    // Read latency from requester 0
    set_req(2'b01, 2'b00, 4'd8, 4'd0, 32'h0, 32'h0);
    step;
    check("lat_gnt_n1", bus.gnt, 2'b01);
    set_req(2'b00, 2'b00, 4'd0, 4'd0, 32'h0, 32'h0);
    step;
    check("lat_rvalid_n2", bus.rvalid, 0);
    step;
    check("lat_rvalid_n3", bus.rvalid, 2'b01);
    check("lat_rdata", bus.rdata, 32'hA5A5_0008);

    set_req(2'b10, 2'b00, 4'd0, 4'd9, 32'h0, 32'h0);
    step;
    check("rd9_gnt", bus.gnt, 2'b10);
    set_req(2'b00, 2'b00, 4'd0, 4'd0, 32'h0, 32'h0);
    step;
    step;
    check("rd9_rvalid", bus.rvalid, 2'b10);
    check("rd9_rdata", bus.rdata, 32'h5A5A_0009);
    check("rd9_err", bus.err, 0);

    // Reset in RESP aborts the read
    set_req(2'b01, 2'b00, 4'd2, 4'd0, 32'h7777_7777, 32'h0);
    step;
    check("ab_gnt", bus.gnt, 2'b01);
    set_req(2'b00, 2'b00, 4'd0, 4'd0, 32'h0, 32'h0);
    step;
    rstn = 1'b0;
    #1;
    check("ab_gnt0", bus.gnt, 0);
    check("ab_rvalid0", bus.rvalid, 0);
    check("ab_rdata0", bus.rdata, 0);
    check("ab_ram_en0", bus.ram_en, 0);
    check("ab_ram_addr0", bus.ram_addr, 0);
    check("ab_ram_wdata0", bus.ram_wdata, 0);
    step;
    rstn = 1'b1;
    step;
    check("ab_no_rvalid_a", bus.rvalid, 0);
    check("ab_no_gnt", bus.gnt, 0);
    step;
    check("ab_no_rvalid_b", bus.rvalid, 0);
    set_req(2'b10, 2'b00, 4'd0, 4'd2, 32'h0, 32'h0);
    step;
    check("post_gnt", bus.gnt, 2'b10);
    set_req(2'b00, 2'b00, 4'd0, 4'd0, 32'h0, 32'h0);
    step;
    step;
    check("post_rvalid", bus.rvalid, 2'b10);
    check("post_rdata", bus.rdata, 32'h1000_0002);

    // RAM withholds ram_valid: err sets and sticks until reset
    force_bad = 1'b1;
    set_req(2'b01, 2'b00, 4'd4, 4'd0, 32'h0, 32'h0);
    step;
    check("err_gnt", bus.gnt, 2'b01);
    set_req(2'b00, 2'b00, 4'd0, 4'd0, 32'h0, 32'h0);
    step;
    check("err_before", bus.err, 0);
    step;
    check("err_set", bus.err, 1);
    check("err_rvalid", bus.rvalid, 2'b01);
    check("err_rdata", bus.rdata, 32'h1000_0004);
    force_bad = 1'b0;
    repeat (3) step;
    check("err_sticky", bus.err, 1);
    rstn = 1'b0;
    #1;
    check("err_cleared", bus.err, 0);
    step;
    rstn = 1'b1;
    step;
    check("err_after_rst", bus.err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
